// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, default lives, tile colours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    PENALTY   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int START_LIVES_DEF = 3;

  // Colour codes shared with the tile renderer.
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] BLACK  = 3'b000;

endpackage

// File: rtl/popcount_n.sv
// Counts the set bits of an N-bit vector.
// Latency: purely combinational.
// Backpressure: none.
module popcount_n #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_bits,
  output logic [CW-1:0] o_cnt
);

  // Ripple sum of the individual bits.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < N; i++) begin
      o_cnt = o_cnt + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/lives_manager.sv
// Game control: tracks lives/score/level and runs IDLE/PLAY/PENALTY/GAME_OVER.
// Latency: tile pulses in cycle N update lives/score/state in cycle N+1; level lags score by 1.
// Backpressure: none; tiles are frozen through tile_enable outside PLAY.
module lives_manager
  import game_pkg::*;
#(
  parameter int          NUM_TILES      = 4,
  parameter int          START_LIVES    = START_LIVES_DEF,
  parameter int          SCORE_W        = 10,
  parameter int          LEVEL_STEP     = 8,
  parameter int          MAX_LEVEL      = 7,
  parameter logic [23:0] PENALTY_CYCLES = 24'd30
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 start_key,
  input  logic [NUM_TILES-1:0] lose_a_life,
  input  logic [NUM_TILES-1:0] tile_clear,
  output logic                 tile_enable,
  output logic [3:0]           lives,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           level,
  output logic                 game_over,
  output logic                 life_lost_flash
);

  localparam int CW = $clog2(NUM_TILES + 1);

  state_t              r_state, w_state_nxt;
  logic                r_start_q;
  logic [3:0]          r_lives, w_lives_nxt;
  logic [SCORE_W-1:0]  r_score, w_score_nxt;
  logic [2:0]          r_level, w_level_nxt;
  logic [23:0]         r_pen, w_pen_nxt;

  logic [CW-1:0]       w_lose_cnt;
  logic [CW-1:0]       w_clr_cnt;
  logic                w_start_pulse;
  logic [SCORE_W:0]    w_score_sum;
  logic signed [4:0]   w_lives_diff;
  logic [3:0]          w_lives_sat;
  logic [SCORE_W-1:0]  w_quot;
  logic [2:0]          w_level_calc;

  popcount_n #(.N(NUM_TILES), .CW(CW)) u_pop_lose (
    .i_bits (lose_a_life),
    .o_cnt  (w_lose_cnt)
  );

  popcount_n #(.N(NUM_TILES), .CW(CW)) u_pop_clr (
    .i_bits (tile_clear),
    .o_cnt  (w_clr_cnt)
  );

  assign w_start_pulse = start_key & ~r_start_q;

  // Extra carry bit flags score overflow for saturation.
  assign w_score_sum  = {1'b0, r_score} + (SCORE_W + 1)'(w_clr_cnt);
  // Sign bit of the 5-bit difference flags lives underflow.
  assign w_lives_diff = $signed({1'b0, r_lives}) - $signed({{(5 - CW){1'b0}}, w_lose_cnt});
  assign w_lives_sat  = w_lives_diff[4] ? 4'd0 : w_lives_diff[3:0];
  assign w_quot       = r_score / SCORE_W'(LEVEL_STEP);
  assign w_level_calc = (w_quot > SCORE_W'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : w_quot[2:0];

  // Next-state and datapath updates for the game sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_score_nxt = r_score;
    w_pen_nxt   = r_pen;
    w_level_nxt = w_level_calc;
    case (r_state)
      IDLE: begin
        if (w_start_pulse) begin
          w_lives_nxt = 4'(START_LIVES);
          w_score_nxt = '0;
          w_level_nxt = '0;
          w_state_nxt = PLAY;
        end
      end
      PLAY: begin
        w_score_nxt = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
        if (w_lose_cnt != '0) begin
          w_lives_nxt = w_lives_sat;
          if (w_lives_sat == 4'd0) begin
            w_state_nxt = GAME_OVER;
          end else begin
            w_pen_nxt   = PENALTY_CYCLES;
            w_state_nxt = PENALTY;
          end
        end
      end
      PENALTY: begin
        // Late pulses from the entry cycle are deliberately dropped here.
        if (r_pen == '0) begin
          w_state_nxt = PLAY;
        end else if (enable) begin
          w_pen_nxt = r_pen - 24'd1;
        end
      end
      GAME_OVER: begin
        // Return to IDLE only; a second press is needed to begin a new game.
        if (w_start_pulse) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; the key register resets high so a key
  // held through reset must be released before it can start a game.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_start_q <= 1'b1;
      r_lives   <= '0;
      r_score   <= '0;
      r_level   <= '0;
      r_pen     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start_key;
      r_lives   <= w_lives_nxt;
      r_score   <= w_score_nxt;
      r_level   <= w_level_nxt;
      r_pen     <= w_pen_nxt;
    end
  end

  assign tile_enable     = (r_state == PLAY);
  assign game_over       = (r_state == GAME_OVER);
  assign life_lost_flash = (r_state == PENALTY);
  assign lives           = r_lives;
  assign score           = r_score;
  assign level           = r_level;

endmodule

// File: tb/tb_lives_manager.sv
module tb_lives_manager;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       start_key;
  logic [3:0] lose_a_life;
  logic [3:0] tile_clear;
  logic       tile_enable;
  logic [3:0] lives;
  logic [9:0] score;
  logic [2:0] level;
  logic       game_over;
  logic       life_lost_flash;

  always #5 clk = ~clk;

  lives_manager #(
    .NUM_TILES(4), .START_LIVES(3), .SCORE_W(10), .LEVEL_STEP(8),
    .MAX_LEVEL(7), .PENALTY_CYCLES(24'd30)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .start_key       (start_key),
    .lose_a_life     (lose_a_life),
    .tile_clear      (tile_clear),
    .tile_enable     (tile_enable),
    .lives           (lives),
    .score           (score),
    .level           (level),
    .game_over       (game_over),
    .life_lost_flash (life_lost_flash)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural game model: a game is either not running, running (possibly
  // frozen for m_freeze more cycles) or over.
  bit m_kprev, m_active, m_over;
  int m_freeze, m_lives, m_score, m_level;

  typedef struct {
    logic       st;
    logic       en;
    logic [3:0] lose;
    logic [3:0] clr;
    int         lives;
    int         score;
    int         level;
    int         te;
    int         go;
    int         fl;
  } vec_t;

  vec_t tbl[9];

  function automatic int pc(logic [3:0] v);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(v[i]);
    return s;
  endfunction

  function automatic vec_t mk(logic st, logic en, logic [3:0] lose, logic [3:0] clr,
                              int lv, int sc, int lvl, int te, int go, int fl);
    vec_t v;
    v.st = st; v.en = en; v.lose = lose; v.clr = clr;
    v.lives = lv; v.score = sc; v.level = lvl; v.te = te; v.go = go; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_kprev = 1'b1; m_active = 1'b0; m_over = 1'b0; m_freeze = -1;
    m_lives = 0; m_score = 0; m_level = 0;
  endtask

  task automatic model_step();
    bit pulse;
    int lvl;
    int nl;
    pulse = start_key && !m_kprev;
    m_kprev = start_key;
    lvl = m_score / 8;
    if (lvl > 7) lvl = 7;
    if (m_over) begin
      if (pulse) m_over = 1'b0;
    end else if (!m_active) begin
      if (pulse) begin
        m_active = 1'b1; m_freeze = -1; m_lives = 3; m_score = 0; lvl = 0;
      end
    end else if (m_freeze >= 0) begin
      if (m_freeze == 0) m_freeze = -1;
      else if (enable) m_freeze--;
    end else begin
      m_score += pc(tile_clear);
      if (m_score > 1023) m_score = 1023;
      nl = pc(lose_a_life);
      if (nl > 0) begin
        m_lives -= nl;
        if (m_lives < 0) m_lives = 0;
        if (m_lives == 0) begin
          m_active = 1'b0; m_over = 1'b1;
        end else begin
          m_freeze = 30;
        end
      end
    end
    m_level = lvl;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".lives"}, int'(lives), m_lives);
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".level"}, int'(level), m_level);
    chk({tag, ".tile_enable"}, int'(tile_enable), int'(m_active && m_freeze < 0));
    chk({tag, ".flash"}, int'(life_lost_flash), int'(m_freeze >= 0));
    chk({tag, ".game_over"}, int'(game_over), int'(m_over));
  endtask

  // Called at a negedge: drive, let one posedge happen, check at the next negedge.
  task automatic cycle(input logic s, input logic e, input logic [3:0] l,
                       input logic [3:0] c, input string tag);
    start_key = s; enable = e; lose_a_life = l; tile_clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    resetn = 1'b0; start_key = 1'b0; enable = 1'b1;
    lose_a_life = '0; tile_clear = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int flash_seen;

    // Reset, start, four double clears, then simultaneous clear+loss.
    tbl[0] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1'b1, 1'b1, 4'b0000, 4'b0000, 3, 0, 0, 1, 0, 0);
    tbl[2] = mk(1'b1, 1'b1, 4'b0000, 4'b0101, 3, 2, 0, 1, 0, 0);
    tbl[3] = mk(1'b0, 1'b1, 4'b0000, 4'b0101, 3, 4, 0, 1, 0, 0);
    tbl[4] = mk(1'b0, 1'b1, 4'b0000, 4'b0101, 3, 6, 0, 1, 0, 0);
    tbl[5] = mk(1'b0, 1'b1, 4'b0000, 4'b0101, 3, 8, 0, 1, 0, 0);
    tbl[6] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 3, 8, 1, 1, 0, 0);
    tbl[7] = mk(1'b0, 1'b1, 4'b1000, 4'b0010, 2, 9, 1, 0, 0, 1);
    tbl[8] = mk(1'b0, 1'b1, 4'b0000, 4'b1111, 2, 9, 1, 0, 0, 1);

    resetn = 1'b0; start_key = 1'b0; enable = 1'b1;
    lose_a_life = '0; tile_clear = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.lives", int'(lives), 0);
    chk("rst.score", int'(score), 0);
    chk("rst.level", int'(level), 0);
    chk("rst.tile_enable", int'(tile_enable), 0);
    chk("rst.game_over", int'(game_over), 0);
    chk("rst.flash", int'(life_lost_flash), 0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].st, tbl[i].en, tbl[i].lose, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.lives", i), int'(lives), tbl[i].lives);
      chk($sformatf("tbl%0d.score", i), int'(score), tbl[i].score);
      chk($sformatf("tbl%0d.level", i), int'(level), tbl[i].level);
      chk($sformatf("tbl%0d.te", i), int'(tile_enable), tbl[i].te);
      chk($sformatf("tbl%0d.go", i), int'(game_over), tbl[i].go);
      chk($sformatf("tbl%0d.flash", i), int'(life_lost_flash), tbl[i].fl);
    end

    // Penalty length: two flash cycles already seen in the table.
    flash_seen = 2;
    for (int i = 0; i < 40 && tile_enable !== 1'b1; i++) begin
      cycle(1'b0, 1'b1, 4'b0000, 4'b0000, "pen");
      if (life_lost_flash === 1'b1) flash_seen++;
    end
    chk("pen.length", flash_seen, 31);
    chk("pen.back_to_play", int'(tile_enable), 1);
    chk("pen.lives", int'(lives), 2);

    // Multi-life loss saturates at zero and ends the game.
    cycle(1'b0, 1'b1, 4'b0111, 4'b0000, "lose3");
    chk("go.lives", int'(lives), 0);
    chk("go.flag", int'(game_over), 1);
    chk("go.te", int'(tile_enable), 0);
    repeat (3) cycle(1'b0, 1'b1, 4'b0001, 4'b1111, "go.hold");
    chk("go.score_held", int'(score), 9);

    // Two presses to restart.
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, "go.press1");
    chk("go.press1.te", int'(tile_enable), 0);
    chk("go.press1.go", int'(game_over), 0);
    cycle(1'b0, 1'b1, 4'b0000, 4'b0000, "go.release");
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, "go.press2");
    chk("go.press2.te", int'(tile_enable), 1);
    chk("go.press2.lives", int'(lives), 3);
    chk("go.press2.score", int'(score), 0);

    // Build some state, enter PENALTY, then reset asynchronously mid-cycle.
    cycle(1'b1, 1'b1, 4'b0000, 4'b1111, "pre");
    cycle(1'b1, 1'b1, 4'b0000, 4'b1111, "pre");
    cycle(1'b1, 1'b1, 4'b0001, 4'b0000, "pre.lose");
    repeat (3) cycle(1'b1, 1'b1, 4'b0000, 4'b0000, "pre.pen");
    chk("pre.flash", int'(life_lost_flash), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst.lives", int'(lives), 0);
    chk("arst.score", int'(score), 0);
    chk("arst.level", int'(level), 0);
    chk("arst.flash", int'(life_lost_flash), 0);
    chk("arst.te", int'(tile_enable), 0);
    chk("arst.go", int'(game_over), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    repeat (3) cycle(1'b1, 1'b1, 4'b0000, 4'b0000, "held");
    chk("held.no_start", int'(tile_enable), 0);
    cycle(1'b0, 1'b1, 4'b0000, 4'b0000, "held.release");
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, "held.repress");
    chk("held.repress.te", int'(tile_enable), 1);

    // Score and level saturation.
    do_reset();
    cycle(1'b0, 1'b1, 4'b0000, 4'b0000, "sat.idle");
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, "sat.start");
    repeat (300) cycle(1'b0, 1'b1, 4'b0000, 4'b1111, "sat");
    chk("sat.score", int'(score), 1023);
    chk("sat.level", int'(level), 7);

    // Randomised play against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic s, e;
      logic [3:0] l, c;
      s = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'b0000;
      c = 4'($urandom) & 4'($urandom);
      cycle(s, e, l, c, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
